// File: rtl/qspi_mem_pkg.sv
// Shared types and constants for the QSPI memory controller.
package qspi_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CS    = 3'd1,
    ST_CMD   = 3'd2,
    ST_ADDR  = 3'd3,
    ST_DUMMY = 3'd4,
    ST_DATA  = 3'd5,
    ST_END   = 3'd6
  } state_e;

  localparam logic [7:0] CMD_QREAD  = 8'hEB;
  localparam logic [7:0] CMD_QWRITE = 8'h38;
  localparam logic [7:0] CMD_QPI_EN = 8'h35;

  localparam int CMD_CYCLES     = 8;
  localparam int CMD_QPI_CYCLES = 2;
  localparam int ADDR_CYCLES    = 6;
  localparam int DATA_CYCLES    = 8;

  // The bus carries byte 0 first; the core word keeps byte 0 in bits [7:0].
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/qspi_shift.sv
// Bit/nibble shifter for the QSPI bus: toggles SCK, shifts data out on the
// falling half and samples IO on the edge that raises SCK.
module qspi_shift (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        quad_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  cycles_i,
  input  logic [3:0]  sdi_i,
  output logic        sck_o,
  output logic [3:0]  sdo_o,
  output logic        last_o,
  output logic [31:0] rx_o
);

  logic        run_q;
  logic        sck_q;
  logic        quad_q;
  logic [3:0]  cnt_q;
  logic [31:0] sr_q;
  logic [3:0]  sdo_q;
  logic [31:0] rx_q;

  // SCK generation, output shifting and input capture.
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      run_q  <= 1'b0;
      sck_q  <= 1'b0;
      quad_q <= 1'b0;
      cnt_q  <= '0;
      sr_q   <= '0;
      sdo_q  <= '0;
      rx_q   <= '0;
    end else if (stop_i) begin
      run_q <= 1'b0;
      sck_q <= 1'b0;
      sdo_q <= '0;
    end else if (start_i) begin
      run_q  <= 1'b1;
      sck_q  <= 1'b0;
      quad_q <= quad_i;
      cnt_q  <= cycles_i - 4'd1;
      sdo_q  <= quad_i ? data_i[31:28] : {3'b000, data_i[31]};
      sr_q   <= quad_i ? (data_i << 4) : (data_i << 1);
    end else if (run_q) begin
      if (!sck_q) begin
        sck_q <= 1'b1;
        rx_q  <= quad_q ? {rx_q[27:0], sdi_i} : {rx_q[30:0], sdi_i[1]};
      end else begin
        sck_q <= 1'b0;
        if (cnt_q != 4'd0) begin
          cnt_q <= cnt_q - 4'd1;
          sdo_q <= quad_q ? sr_q[31:28] : {3'b000, sr_q[31]};
          sr_q  <= quad_q ? (sr_q << 4) : (sr_q << 1);
        end else begin
          run_q <= 1'b0;
        end
      end
    end
  end

  assign sck_o  = sck_q;
  assign sdo_o  = sdo_q;
  assign rx_o   = rx_q;
  assign last_o = run_q & sck_q & (cnt_q == 4'd0);

endmodule

// File: rtl/qspi_mem_ctrl.sv
// QSPI controller for boot flash (read-only) and PSRAM, one word per request.
// Optional: define PSRAM_QPI_INIT_EN to switch the PSRAM into quad command
// mode after reset (0x35 on IO0) so later PSRAM commands take 2 SCK cycles.
//
// state    | meaning
// IDLE     | wait for request (or start PSRAM init), CS high
// CS       | CS asserted, SCK low, first command bit prepared
// CMD      | command byte, serial on IO0 (quad when PSRAM is in QPI mode)
// ADDR     | 24-bit address, 6 nibbles
// DUMMY    | read turnaround, IO released
// DATA     | 8 nibbles of data, little-endian bytes
// END      | CS released, ack pulse, rdata updated
module qspi_mem_ctrl
  import qspi_mem_pkg::*;
#(
  parameter int FLASH_DUMMY = 8,
  parameter int RAM_DUMMY   = 6
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        req_i,
  input  logic        we_i,
  input  logic        ram_i,
  input  logic [23:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        cs_rom_on,
  output logic        cs_ram_on,
  output logic        sck_o,
  output logic [3:0]  sdo_o,
  input  logic [3:0]  sdi_i,
  output logic [3:0]  oen_o
);

  state_e      state_q, state_d;
  logic        cs_rom_q, cs_rom_d;
  logic        cs_ram_q, cs_ram_d;
  logic [3:0]  oen_q, oen_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ram_q, ram_d;
  logic        we_q, we_d;
  logic [21:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        init_q, init_d;
  logic        qpi_q, qpi_d;

  logic        sh_start, sh_stop, sh_quad, sh_last, sh_sck;
  logic [31:0] sh_data, sh_rx;
  logic [3:0]  sh_cycles, sh_sdo;
  logic        start_data, cmd_quad, init_pend;
  logic [7:0]  cmd_sel;
  logic [3:0]  dummy_cyc;
  logic        unused_addr;

  assign unused_addr = ^addr_i[1:0];

`ifdef PSRAM_QPI_INIT_EN
  assign init_pend = ~qpi_q;
`else
  assign init_pend = 1'b0;
`endif

  assign cmd_quad  = ram_q & qpi_q;
  assign cmd_sel   = init_q ? CMD_QPI_EN : (we_q ? CMD_QWRITE : CMD_QREAD);
  assign dummy_cyc = ram_q ? 4'(RAM_DUMMY) : 4'(FLASH_DUMMY);

  qspi_shift u_shift (
    .clk_i    (clk_i),
    .rst_in   (rst_in),
    .start_i  (sh_start),
    .stop_i   (sh_stop),
    .quad_i   (sh_quad),
    .data_i   (sh_data),
    .cycles_i (sh_cycles),
    .sdi_i    (sdi_i),
    .sck_o    (sh_sck),
    .sdo_o    (sh_sdo),
    .last_o   (sh_last),
    .rx_o     (sh_rx)
  );

  // State and latched-request registers.
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      state_q  <= ST_IDLE;
      cs_rom_q <= 1'b1;
      cs_ram_q <= 1'b1;
      oen_q    <= 4'hF;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      ram_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      init_q   <= 1'b0;
      qpi_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cs_rom_q <= cs_rom_d;
      cs_ram_q <= cs_ram_d;
      oen_q    <= oen_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      ram_q    <= ram_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      init_q   <= init_d;
      qpi_q    <= qpi_d;
    end
  end

  // Next-state logic and phase sequencing of the shifter.
  always_comb begin
    state_d    = state_q;
    cs_rom_d   = cs_rom_q;
    cs_ram_d   = cs_ram_q;
    oen_d      = oen_q;
    ack_d      = 1'b0;
    rdata_d    = rdata_q;
    ram_d      = ram_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    init_d     = init_q;
    qpi_d      = qpi_q;
    sh_start   = 1'b0;
    sh_stop    = 1'b0;
    sh_quad    = 1'b0;
    sh_data    = '0;
    sh_cycles  = '0;
    start_data = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (init_pend) begin
          init_d   = 1'b1;
          ram_d    = 1'b1;
          we_d     = 1'b0;
          cs_ram_d = 1'b0;
          state_d  = ST_CS;
        end else if (req_i && !ack_q) begin
          if (we_i && !ram_i) begin
            // flash is read-only: complete without touching the bus
            ack_d = 1'b1;
          end else begin
            ram_d    = ram_i;
            we_d     = we_i;
            addr_d   = addr_i[23:2];
            wdata_d  = wdata_i;
            init_d   = 1'b0;
            cs_rom_d = ram_i;
            cs_ram_d = ~ram_i;
            state_d  = ST_CS;
          end
        end
      end
      ST_CS: begin
        sh_start  = 1'b1;
        sh_data   = {cmd_sel, 24'h000000};
        sh_quad   = cmd_quad;
        sh_cycles = cmd_quad ? 4'(CMD_QPI_CYCLES) : 4'(CMD_CYCLES);
        oen_d     = cmd_quad ? 4'h0 : 4'b1110;
        state_d   = ST_CMD;
      end
      ST_CMD: begin
        if (sh_last) begin
          if (init_q) begin
            sh_stop  = 1'b1;
            cs_ram_d = 1'b1;
            oen_d    = 4'hF;
            qpi_d    = 1'b1;
            state_d  = ST_END;
          end else begin
            sh_start  = 1'b1;
            sh_data   = {addr_q, 2'b00, 8'h00};
            sh_quad   = 1'b1;
            sh_cycles = 4'(ADDR_CYCLES);
            oen_d     = 4'h0;
            state_d   = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (sh_last) begin
          if (!we_q && dummy_cyc != 4'd0) begin
            sh_start  = 1'b1;
            sh_quad   = 1'b1;
            sh_cycles = dummy_cyc;
            oen_d     = 4'hF;
            state_d   = ST_DUMMY;
          end else begin
            start_data = 1'b1;
          end
        end
      end
      ST_DUMMY: begin
        if (sh_last) start_data = 1'b1;
      end
      ST_DATA: begin
        if (sh_last) begin
          sh_stop  = 1'b1;
          cs_rom_d = 1'b1;
          cs_ram_d = 1'b1;
          oen_d    = 4'hF;
          ack_d    = 1'b1;
          if (!we_q) rdata_d = byte_swap(sh_rx);
          state_d  = ST_END;
        end
      end
      ST_END: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (start_data) begin
      sh_start  = 1'b1;
      sh_data   = we_q ? byte_swap(wdata_q) : 32'h0;
      sh_quad   = 1'b1;
      sh_cycles = 4'(DATA_CYCLES);
      oen_d     = we_q ? 4'h0 : 4'hF;
      state_d   = ST_DATA;
    end
  end

  assign rdata_o   = rdata_q;
  assign ack_o     = ack_q;
  assign cs_rom_on = cs_rom_q;
  assign cs_ram_on = cs_ram_q;
  assign sck_o     = sh_sck;
  assign sdo_o     = sh_sdo;
  assign oen_o     = oen_q;

endmodule

// File: tb/tb_qspi_mem_ctrl.sv
module tb_qspi_mem_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_in, req_i, we_i, ram_i;
  logic [23:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o, cs_rom_on, cs_ram_on, sck_o;
  logic [3:0]  sdo_o, oen_o;
  logic [3:0]  sdi_i = 4'h0;

  int vectors, miscompares;

  // memory model state (owned by the model process)
  logic [7:0]  rom_mem [1024];
  logic [7:0]  ram_mem [1024];
  logic [7:0]  m_cmd;
  logic [23:0] m_addr;
  int rom_xfers, ram_xfers, oen_cmd_bad, oen_rd_bad;

  qspi_mem_ctrl dut (
    .clk_i     (clk_i),
    .rst_in    (rst_in),
    .req_i     (req_i),
    .we_i      (we_i),
    .ram_i     (ram_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .rdata_o   (rdata_o),
    .ack_o     (ack_o),
    .cs_rom_on (cs_rom_on),
    .cs_ram_on (cs_ram_on),
    .sck_o     (sck_o),
    .sdo_o     (sdo_o),
    .sdi_i     (sdi_i),
    .oen_o     (oen_o)
  );

  always #5 clk_i = ~clk_i;

  // Flash/PSRAM slave model: mode 0, samples on SCK rise, drives on SCK fall.
  initial begin
    int n, k, d, idx;
    logic prev_sck, prev_act, m_rom;
    logic [7:0] b;
    for (int i = 0; i < 1024; i++) begin
      rom_mem[i] = 8'(i * 7 + 3);
      ram_mem[i] = 8'h00;
    end
    rom_mem[0] = 8'h44; rom_mem[1] = 8'h33; rom_mem[2] = 8'h22; rom_mem[3] = 8'h11;
    rom_mem[516] = 8'hA0; rom_mem[517] = 8'hB1; rom_mem[518] = 8'hC2; rom_mem[519] = 8'hD3;
    n = 0; prev_sck = 1'b0; prev_act = 1'b0; m_rom = 1'b0;
    m_cmd = 8'h00; m_addr = 24'h0;
    rom_xfers = 0; ram_xfers = 0; oen_cmd_bad = 0; oen_rd_bad = 0;
    forever begin
      @(posedge clk_i); #1;
      if (cs_rom_on && cs_ram_on) begin
        n = 0;
        sdi_i = 4'h0;
      end else begin
        if (!prev_act) begin
          m_rom = ~cs_rom_on;
          if (m_rom) rom_xfers++; else ram_xfers++;
        end
        if (sck_o && !prev_sck) begin
          if (n < 8) begin
            m_cmd = {m_cmd[6:0], sdo_o[0]};
            if (oen_o !== 4'b1110) oen_cmd_bad++;
          end else if (n < 14) begin
            m_addr = {m_addr[19:0], sdo_o};
          end else if (m_cmd == 8'h38 && !m_rom && n < 22) begin
            k = n - 14;
            idx = (int'(m_addr) + k / 2) & 1023;
            if (k % 2 == 0) ram_mem[idx][7:4] = sdo_o;
            else ram_mem[idx][3:0] = sdo_o;
          end else if (m_cmd == 8'hEB && oen_o !== 4'hF) begin
            oen_rd_bad++;
          end
          n++;
        end else if (!sck_o && prev_sck && m_cmd == 8'hEB) begin
          d = m_rom ? 8 : 6;
          k = n - 14 - d;
          if (k >= 0 && k < 8) begin
            idx = (int'(m_addr) + k / 2) & 1023;
            b = m_rom ? rom_mem[idx] : ram_mem[idx];
            sdi_i = (k % 2 == 0) ? b[7:4] : b[3:0];
          end
        end
      end
      prev_sck = sck_o;
      prev_act = ~(cs_rom_on && cs_ram_on);
    end
  end

  // One request held until ack; returns data, latency and CS-low cycle counts.
  task automatic do_xfer(input logic we, input logic ram, input logic [23:0] a,
                         input logic [31:0] wd, output logic [31:0] rd,
                         output int lat, output int rom_lo, output int ram_lo);
    we_i = we; ram_i = ram; addr_i = a; wdata_i = wd; req_i = 1'b1;
    lat = 0; rom_lo = 0; ram_lo = 0; rd = 32'hxxxxxxxx;
    while (lat < 300) begin
      @(posedge clk_i); #1;
      lat++;
      if (!cs_rom_on) rom_lo++;
      if (!cs_ram_on) ram_lo++;
      if (ack_o) begin
        rd = rdata_o;
        break;
      end
    end
    req_i = 1'b0;
    @(posedge clk_i); #1;
    vectors++;
    if (ack_o !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_width: ack_o=%b one cycle after ack, want 0", ack_o);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    vectors += 7;
    if (cs_rom_on !== 1'b1) begin miscompares++; $display("FAIL rst_cs_rom: got %b want 1", cs_rom_on); end
    if (cs_ram_on !== 1'b1) begin miscompares++; $display("FAIL rst_cs_ram: got %b want 1", cs_ram_on); end
    if (sck_o !== 1'b0) begin miscompares++; $display("FAIL rst_sck: got %b want 0", sck_o); end
    if (sdo_o !== 4'h0) begin miscompares++; $display("FAIL rst_sdo: got %h want 0", sdo_o); end
    if (oen_o !== 4'hF) begin miscompares++; $display("FAIL rst_oen: got %h want f", oen_o); end
    if (ack_o !== 1'b0) begin miscompares++; $display("FAIL rst_ack: got %b want 0", ack_o); end
    if (rdata_o !== 32'h0) begin miscompares++; $display("FAIL rst_rdata: got %h want 0", rdata_o); end
    rst_in = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_flash_read();
    logic [31:0] rd;
    int lat, rlo, mlo, cb, rb;
    cb = oen_cmd_bad; rb = oen_rd_bad;
    do_xfer(1'b0, 1'b0, 24'h100000, 32'h0, rd, lat, rlo, mlo);
    vectors += 8;
    if (rd !== 32'h11223344) begin miscompares++; $display("FAIL flash_rdata: got %h want 11223344", rd); end
    if (lat != 62) begin miscompares++; $display("FAIL flash_latency: got %0d want 62", lat); end
    if (rlo != 61) begin miscompares++; $display("FAIL flash_cs_rom_low: got %0d want 61", rlo); end
    if (mlo != 0) begin miscompares++; $display("FAIL flash_cs_ram_low: got %0d want 0", mlo); end
    if (m_cmd !== 8'hEB) begin miscompares++; $display("FAIL flash_cmd_bits: got %h want eb", m_cmd); end
    if (m_addr !== 24'h100000) begin miscompares++; $display("FAIL flash_addr: got %h want 100000", m_addr); end
    if (oen_cmd_bad != cb) begin miscompares++; $display("FAIL flash_oen_cmd: %0d bad SCK, want 0", oen_cmd_bad - cb); end
    if (oen_rd_bad != rb) begin miscompares++; $display("FAIL flash_oen_read: %0d bad SCK, want 0", oen_rd_bad - rb); end
    // low address bits are ignored
    do_xfer(1'b0, 1'b0, 24'h000207, 32'h0, rd, lat, rlo, mlo);
    vectors += 2;
    if (rd !== 32'hD3C2B1A0) begin miscompares++; $display("FAIL flash_unaligned: got %h want d3c2b1a0", rd); end
    if (m_addr !== 24'h000204) begin miscompares++; $display("FAIL flash_addr_align: got %h want 000204", m_addr); end
  endtask

  task automatic test_ram_write_read();
    logic [31:0] rd;
    int lat, rlo, mlo, rb;
    do_xfer(1'b1, 1'b1, 24'h000010, 32'hDEADBEEF, rd, lat, rlo, mlo);
    vectors += 5;
    if (lat != 46) begin miscompares++; $display("FAIL ram_wr_latency: got %0d want 46", lat); end
    if (mlo != 45) begin miscompares++; $display("FAIL ram_wr_cs_low: got %0d want 45", mlo); end
    if (rlo != 0) begin miscompares++; $display("FAIL ram_wr_cs_rom: got %0d want 0", rlo); end
    if (m_cmd !== 8'h38) begin miscompares++; $display("FAIL ram_wr_cmd: got %h want 38", m_cmd); end
    if ({ram_mem[19], ram_mem[18], ram_mem[17], ram_mem[16]} !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL ram_wr_bytes: got %h%h%h%h want deadbeef", ram_mem[19], ram_mem[18], ram_mem[17], ram_mem[16]);
    end
    rb = oen_rd_bad;
    do_xfer(1'b0, 1'b1, 24'h000010, 32'h0, rd, lat, rlo, mlo);
    vectors += 3;
    if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ram_rd_data: got %h want deadbeef", rd); end
    if (lat != 58) begin miscompares++; $display("FAIL ram_rd_latency: got %0d want 58", lat); end
    if (oen_rd_bad != rb) begin miscompares++; $display("FAIL ram_rd_oen: %0d bad SCK, want 0", oen_rd_bad - rb); end
    do_xfer(1'b1, 1'b1, 24'h000014, 32'h01234567, rd, lat, rlo, mlo);
    do_xfer(1'b0, 1'b1, 24'h000014, 32'h0, rd, lat, rlo, mlo);
    vectors += 1;
    if (rd !== 32'h01234567) begin miscompares++; $display("FAIL ram_rd_data2: got %h want 01234567", rd); end
  endtask

  task automatic test_invalid_write();
    logic [31:0] rd;
    int lat, rlo, mlo, rx, mx;
    rx = rom_xfers; mx = ram_xfers;
    do_xfer(1'b1, 1'b0, 24'h100000, 32'hCAFEF00D, rd, lat, rlo, mlo);
    vectors += 5;
    if (lat != 1) begin miscompares++; $display("FAIL badwr_latency: got %0d want 1", lat); end
    if (rlo != 0 || mlo != 0) begin miscompares++; $display("FAIL badwr_cs: rom_low=%0d ram_low=%0d want 0,0", rlo, mlo); end
    if (rom_xfers != rx || ram_xfers != mx) begin miscompares++; $display("FAIL badwr_bus: %0d transfers seen, want 0", rom_xfers - rx + ram_xfers - mx); end
    if (rdata_o !== 32'h01234567) begin miscompares++; $display("FAIL badwr_rdata_hold: got %h want 01234567", rdata_o); end
    if (rom_mem[0] !== 8'h44) begin miscompares++; $display("FAIL badwr_flash: byte0=%h want 44", rom_mem[0]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int lat, rlo, mlo, acks;
    we_i = 1'b0; ram_i = 1'b0; addr_i = 24'h100000; req_i = 1'b1;
    repeat (20) @(posedge clk_i);
    #1;
    vectors += 1;
    if (cs_rom_on !== 1'b0) begin miscompares++; $display("FAIL mid_in_xfer: cs_rom_on=%b want 0", cs_rom_on); end
    rst_in = 1'b0; req_i = 1'b0;
    @(posedge clk_i); #1;
    vectors += 5;
    if (cs_rom_on !== 1'b1 || cs_ram_on !== 1'b1) begin miscompares++; $display("FAIL mid_rst_cs: rom=%b ram=%b want 1,1", cs_rom_on, cs_ram_on); end
    if (sck_o !== 1'b0) begin miscompares++; $display("FAIL mid_rst_sck: got %b want 0", sck_o); end
    if (oen_o !== 4'hF) begin miscompares++; $display("FAIL mid_rst_oen: got %h want f", oen_o); end
    if (sdo_o !== 4'h0) begin miscompares++; $display("FAIL mid_rst_sdo: got %h want 0", sdo_o); end
    if (ack_o !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ack: got %b want 0", ack_o); end
    @(posedge clk_i); #1;
    rst_in = 1'b1;
    acks = 0;
    repeat (6) begin
      @(posedge clk_i); #1;
      if (ack_o) acks++;
    end
    vectors += 1;
    if (acks != 0) begin miscompares++; $display("FAIL mid_rst_no_ack: %0d ack cycles, want 0", acks); end
    do_xfer(1'b0, 1'b0, 24'h100000, 32'h0, rd, lat, rlo, mlo);
    vectors += 2;
    if (rd !== 32'h11223344) begin miscompares++; $display("FAIL mid_rst_reread: got %h want 11223344", rd); end
    if (lat != 62) begin miscompares++; $display("FAIL mid_rst_latency: got %0d want 62", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd1, rd2;
    int acks, run, maxrun, gap, cyc;
    we_i = 1'b0; ram_i = 1'b0; addr_i = 24'h000204; req_i = 1'b1;
    acks = 0; run = 0; maxrun = 0; gap = 0; cyc = 0;
    rd1 = 32'h0; rd2 = 32'h0;
    while (acks < 2 && cyc < 400) begin
      @(posedge clk_i); #1;
      cyc++;
      if (ack_o) begin
        run++;
        if (run == 1) begin
          acks++;
          if (acks == 1) rd1 = rdata_o; else rd2 = rdata_o;
        end
      end else begin
        run = 0;
      end
      if (run > maxrun) maxrun = run;
      if (acks == 1 && cs_rom_on && cs_ram_on) gap++;
    end
    req_i = 1'b0;
    @(posedge clk_i); #1;
    if (ack_o) maxrun = run + 1;
    vectors += 5;
    if (acks != 2) begin miscompares++; $display("FAIL b2b_acks: got %0d want 2", acks); end
    if (maxrun != 1) begin miscompares++; $display("FAIL b2b_ack_width: got %0d want 1", maxrun); end
    if (gap < 1) begin miscompares++; $display("FAIL b2b_cs_gap: got %0d want >=1", gap); end
    if (rd1 !== 32'hD3C2B1A0) begin miscompares++; $display("FAIL b2b_rdata1: got %h want d3c2b1a0", rd1); end
    if (rd2 !== 32'hD3C2B1A0) begin miscompares++; $display("FAIL b2b_rdata2: got %h want d3c2b1a0", rd2); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_in = 1'b0; req_i = 1'b0; we_i = 1'b0; ram_i = 1'b0;
    addr_i = 24'h0; wdata_i = 32'h0;
    test_reset();
    test_flash_read();
    test_ram_write_read();
    test_invalid_write();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
